// File: rtl/lsu_data_memory.sv
// lsu_data_memory
// Byte-addressable, little-endian data memory for the load/store stage.
// A single request is accepted through a valid/ready handshake. It waits
// WAIT_STATES extra cycles and then presents a response through a second
// valid/ready handshake. The memory supports byte, half, word and (for
// 64-bit builds) dword accesses. Loads are sign- or zero-extended.
// Misaligned, out-of-range and illegal-size accesses are flagged in
// rsp_err_o. They never write memory and always return zero data.
//
// Parameters
//   DATA_WIDTH   data path width, 32 or 64
//   ADDR_WIDTH   byte address width
//   DEPTH_BYTES  memory size in bytes (power of two, >= DATA_WIDTH/8)
//   WAIT_STATES  extra cycles between accept and response, 0..15
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    request accepted when req_valid_i && req_ready_o
//   req_we_i       1 = store, 0 = load
//   req_addr_i     byte address
//   req_size_i     00 byte, 01 half, 10 word, 11 dword
//   req_unsigned_i loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata_i    store data, low 2^size bytes used
//   rsp_valid_o    response present
//   rsp_ready_i    response consumed when rsp_valid_o && rsp_ready_i
//   rsp_rdata_o    extended load result, 0 for stores and errors
//   rsp_err_o      misaligned / out-of-range / illegal size
//
// Build option
//   MEM_CLEAR_EN   when defined, every reset is followed by a CLEAR sweep.
//                  The sweep zeroes one DATA_WIDTH/8-byte word per cycle
//                  before the block accepts its first request.

module lsu_data_memory #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_BYTES = 16384,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(DEPTH_BYTES);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_CLEAR
   } state_e;

   state_e state_q, state_d;
   logic [3:0] waitCnt_q, waitCnt_d;

   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            size_q;
   logic                  unsigned_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic [7:0] mem [DEPTH_BYTES];

   logic                  accept;
   logic                  commit;
   logic                  accWe;
   logic [ADDR_WIDTH-1:0] accAddr;
   logic [1:0]            accSize;
   logic                  accUnsigned;
   logic [DATA_WIDTH-1:0] accWdata;
   logic [IDX_W-1:0]      accIdx;
   logic [3:0]            accBytes;
   logic [ADDR_WIDTH:0]   endAddr;
   logic                  misaligned;
   logic                  outOfRange;
   logic                  illegalSize;
   logic                  accErr;
   logic [DATA_WIDTH-1:0] loadRaw;
   logic [DATA_WIDTH-1:0] loadExt;
   logic                  signBit;

`ifdef MEM_CLEAR_EN
   localparam int NWORDS = DEPTH_BYTES / NBYTES;
   logic [IDX_W-1:0] clearCnt_q;
   logic [IDX_W-1:0] clearBase;
   logic             clearLast;

   assign clearBase = clearCnt_q << $clog2(NBYTES);
   assign clearLast = (clearCnt_q == IDX_W'(NWORDS - 1));
`endif

   // A request is only taken while idle and outside reset.
   assign accept = req_valid_i && (state_q == S_IDLE) && !rst_i;

   // The access is committed on the edge that enters RESP. With zero wait
   // states that is the accept edge itself, so the access fields must come
   // straight from the request port rather than from the latches.
   assign commit = ((state_q == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                   ((state_q == S_WAIT) && (waitCnt_q == 4'd0));

   always_comb begin
      accWe       = we_q;
      accAddr     = addr_q;
      accSize     = size_q;
      accUnsigned = unsigned_q;
      accWdata    = wdata_q;
      if (state_q == S_IDLE) begin
         accWe       = req_we_i;
         accAddr     = req_addr_i;
         accSize     = req_size_i;
         accUnsigned = req_unsigned_i;
         accWdata    = req_wdata_i;
      end
   end

   assign accIdx = accAddr[IDX_W-1:0];

   // The error checks use one extra address bit. This stops an access that
   // ends just past the top of the address space from wrapping round and
   // passing the range check.
   always_comb begin
      accBytes = 4'd1 << accSize;
      case (accSize)
         2'd1:    misaligned = accAddr[0];
         2'd2:    misaligned = |accAddr[1:0];
         2'd3:    misaligned = |accAddr[2:0];
         default: misaligned = 1'b0;
      endcase
      endAddr     = {1'b0, accAddr} + (ADDR_WIDTH + 1)'(accBytes);
      outOfRange  = endAddr > DEPTH_EXT;
      illegalSize = (accSize == 2'd3) && (DATA_WIDTH == 32);
      accErr      = misaligned | outOfRange | illegalSize;
   end

   // The load path assembles the addressed bytes little-endian. Every byte
   // above the access size is then filled with copies of the top loaded
   // bit, or with zero. A full-width access has no bytes left to fill.
   always_comb begin
      loadRaw = '0;
      for (int b = 0; b < NBYTES; b++) begin
         if (b < int'(accBytes)) begin
            loadRaw[8*b +: 8] = mem[accIdx + IDX_W'(b)];
         end
      end
      case (accSize)
         2'd0:    signBit = loadRaw[7];
         2'd1:    signBit = loadRaw[15];
         2'd2:    signBit = loadRaw[31];
         default: signBit = loadRaw[DATA_WIDTH-1];
      endcase
      loadExt = loadRaw;
      if (!accUnsigned && signBit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (b >= int'(accBytes)) begin
               loadExt[8*b +: 8] = 8'hFF;
            end
         end
      end
   end

   // This is the memory array. Reset has priority, so a commit that lands
   // on a reset edge is dropped. The optional clear sweep zeroes one word
   // per cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
`ifdef MEM_CLEAR_EN
         if (state_q == S_CLEAR) begin
            for (int b = 0; b < NBYTES; b++) begin
               mem[clearBase + IDX_W'(b)] <= 8'h00;
            end
         end
`endif
         if (commit && accWe && !accErr) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (b < int'(accBytes)) begin
                  mem[accIdx + IDX_W'(b)] <= accWdata[8*b +: 8];
               end
            end
         end
      end
   end

   // This register holds the FSM state and the wait counter. Reset lands in
   // IDLE, or in CLEAR when the clear sweep is built in.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
`ifdef MEM_CLEAR_EN
         state_q <= S_CLEAR;
`else
         state_q <= S_IDLE;
`endif
         waitCnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // This block holds the next-state logic. RESP always returns to IDLE, so
   // a new request can never be accepted in the same cycle a response is
   // consumed.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_STATES > 0) begin
                  state_d   = S_WAIT;
                  waitCnt_d = WAIT_LOAD;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (waitCnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
`ifdef MEM_CLEAR_EN
            if (clearLast) begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // These registers latch the request on accept and capture the response
   // on the commit edge. The response then stays stable through RESP.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         size_q     <= 2'd0;
         unsigned_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            we_q       <= req_we_i;
            addr_q     <= req_addr_i;
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            wdata_q    <= req_wdata_i;
         end
         if (commit) begin
            rdata_q <= (accWe || accErr) ? '0 : loadExt;
            err_q   <= accErr;
         end
      end
   end

`ifdef MEM_CLEAR_EN
   // The sweep counter restarts from word 0 whenever reset is seen.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clearCnt_q <= '0;
      end else if (state_q == S_CLEAR) begin
         clearCnt_q <= clearCnt_q + IDX_W'(1);
      end
   end
`endif

   assign req_ready_o = (state_q == S_IDLE) && !rst_i;
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// tb_lsu_data_memory
// This bench drives two copies of lsu_data_memory. One has no wait states
// and the other has three. Both share the request fields and rsp_ready, but
// each has its own req_valid. A directed table and a randomised run are
// checked against a byte-array model of the memory. Hand-written sequences
// cover response stalls and reset during a wait.

module tb_lsu_data_memory;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 16384;

   logic          clk = 1'b0;
   logic          rst;
   logic          reqValid0, reqValid3;
   logic          reqWe;
   logic [AW-1:0] reqAddr;
   logic [1:0]    reqSize;
   logic          reqUnsigned;
   logic [DW-1:0] reqWdata;
   logic          rspReady;
   logic          reqReady0, reqReady3;
   logic          rspValid0, rspValid3;
   logic [DW-1:0] rspRdata0, rspRdata3;
   logic          rspErr0, rspErr3;

   int assertCount = 0;
   int failCount   = 0;

   // The model memory holds only bytes that have actually been written.
   bit [7:0] refMem [int];

   typedef struct {
      string       name;
      bit          we;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          uns;
      logic [31:0] wdata;
      logic [31:0] expRd;
      bit          expErr;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   lsu_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid0), .req_ready_o(reqReady0),
      .req_we_i(reqWe), .req_addr_i(reqAddr), .req_size_i(reqSize),
      .req_unsigned_i(reqUnsigned), .req_wdata_i(reqWdata),
      .rsp_valid_o(rspValid0), .rsp_ready_i(rspReady),
      .rsp_rdata_o(rspRdata0), .rsp_err_o(rspErr0)
   );

   lsu_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_BYTES(DEPTH), .WAIT_STATES(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid3), .req_ready_o(reqReady3),
      .req_we_i(reqWe), .req_addr_i(reqAddr), .req_size_i(reqSize),
      .req_unsigned_i(reqUnsigned), .req_wdata_i(reqWdata),
      .rsp_valid_o(rspValid3), .rsp_ready_i(rspReady),
      .rsp_rdata_o(rspRdata3), .rsp_err_o(rspErr3)
   );

   // This task compares one observed value with its expected value and
   // keeps the running counts.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // This function is the reference model. It computes the expected result
   // from the address, size and data, then applies any legal store to the
   // model memory.
   function automatic void modelAccess(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                       input bit uns, input logic [31:0] wdata,
                                       output logic [31:0] expRd, output bit expErr, output bit known);
      longint unsigned nb = 64'd1 << size;
      longint unsigned a  = 64'(addr);
      longint unsigned v  = 0;
      longint          sv;
      expErr = ((a % nb) != 0) || (a + nb > DEPTH) || (size == 2'd3 && DW == 32);
      expRd  = '0;
      known  = 1'b1;
      if (expErr) return;
      if (we) begin
         for (int i = 0; i < int'(nb); i++) refMem[int'(a) + i] = wdata[8*i +: 8];
      end else begin
         for (int i = 0; i < int'(nb); i++) begin
            if (!refMem.exists(int'(a) + i)) known = 1'b0;
            else v += longint'(refMem[int'(a) + i]) << (8 * i);
         end
         sv = longint'(v);
         if (!uns && v >= (64'd1 << (8 * nb - 1))) sv = sv - (longint'(1) << (8 * nb));
         expRd = sv[31:0];
      end
   endfunction

   // This task sends one request to both copies with rsp_ready held high.
   // It records each copy's response and its latency in cycles after the
   // accept edge.
   task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                input bit uns, input logic [31:0] wdata,
                                output logic [31:0] rd0, output bit err0, output int lat0,
                                output logic [31:0] rd3, output bit err3, output int lat3);
      bit got0 = 1'b0;
      bit got3 = 1'b0;
      rd0 = '0; rd3 = '0; err0 = 1'b0; err3 = 1'b0; lat0 = -1; lat3 = -1;
      @(negedge clk);
      reqWe = we; reqAddr = addr; reqSize = size; reqUnsigned = uns; reqWdata = wdata;
      rspReady = 1'b1; reqValid0 = 1'b1; reqValid3 = 1'b1;
      @(posedge clk);
      #1;
      reqValid0 = 1'b0; reqValid3 = 1'b0;
      for (int k = 1; k <= 30 && !(got0 && got3); k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("busyReady0", 64'(reqReady0), 64'd0);
         if (!got0 && rspValid0) begin got0 = 1'b1; lat0 = k; rd0 = rspRdata0; err0 = rspErr0; end
         if (!got3 && rspValid3) begin got3 = 1'b1; lat3 = k; rd3 = rspRdata3; err3 = rspErr3; end
      end
      @(posedge clk);
   endtask

   // This task runs one request through applyStimulus and checks both
   // copies against the given expectation.
   task automatic runChecked(input string name, input bit we, input logic [31:0] addr, input logic [1:0] size,
                             input bit uns, input logic [31:0] wdata,
                             input logic [31:0] expRd, input bit expErr, input bit checkRd);
      logic [31:0] rd0, rd3;
      bit err0, err3;
      int lat0, lat3;
      applyStimulus(we, addr, size, uns, wdata, rd0, err0, lat0, rd3, err3, lat3);
      checkOutput({name, ".lat0"}, 64'(lat0), 64'd1);
      checkOutput({name, ".lat3"}, 64'(lat3), 64'd4);
      checkOutput({name, ".err0"}, 64'(err0), 64'(expErr));
      checkOutput({name, ".err3"}, 64'(err3), 64'(expErr));
      if (checkRd) begin
         checkOutput({name, ".rdata0"}, 64'(rd0), 64'(expRd));
         checkOutput({name, ".rdata3"}, 64'(rd3), 64'(expRd));
      end
   endtask

   // This task waits a bounded number of cycles for both copies to be
   // ready again after a reset.
   task automatic waitReady(input string name);
      bit ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = reqReady0 && reqReady3;
      end
      checkOutput(name, 64'(ok), 64'd1);
   endtask

   initial begin
      logic [31:0] expRd, cap;
      bit          expErr, known, early, stable;

      rst = 1'b1; reqValid0 = 1'b0; reqValid3 = 1'b0; reqWe = 1'b0; reqAddr = '0;
      reqSize = 2'd0; reqUnsigned = 1'b0; reqWdata = '0; rspReady = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstReady0", 64'(reqReady0), 64'd0);
      checkOutput("rstReady3", 64'(reqReady3), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idleReady0", 64'(reqReady0), 64'd1);
      checkOutput("idleReady3", 64'(reqReady3), 64'd1);
      checkOutput("rstOut0", {rspValid0, rspErr0, rspRdata0}, 64'd0);
      checkOutput("rstOut3", {rspValid3, rspErr3, rspRdata3}, 64'd0);

      // Directed vector table
      vecs.push_back('{"stW10",    1'b1, 32'h10,       2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
      vecs.push_back('{"ldW10",    1'b0, 32'h10,       2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
      vecs.push_back('{"stB11",    1'b1, 32'h11,       2'd0, 1'b0, 32'h12345680, 32'h0,        1'b0});
      vecs.push_back('{"ldBs11",   1'b0, 32'h11,       2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0});
      vecs.push_back('{"ldBu11",   1'b0, 32'h11,       2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0});
      vecs.push_back('{"ldW10b",   1'b0, 32'h10,       2'd2, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0});
      vecs.push_back('{"ldH13",    1'b0, 32'h13,       2'd1, 1'b0, 32'h0,        32'h0,        1'b1});
      vecs.push_back('{"ldHu12",   1'b0, 32'h12,       2'd1, 1'b1, 32'h0,        32'h0000DEAD, 1'b0});
      vecs.push_back('{"ldHs12",   1'b0, 32'h12,       2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0});
      vecs.push_back('{"stW3FFC",  1'b1, 32'h3FFC,     2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0});
      vecs.push_back('{"stW3FFE",  1'b1, 32'h3FFE,     2'd2, 1'b0, 32'h11223344, 32'h0,        1'b1});
      vecs.push_back('{"ldW3FFC",  1'b0, 32'h3FFC,     2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0});
      vecs.push_back('{"stH3FFE",  1'b1, 32'h3FFE,     2'd1, 1'b0, 32'h0000AAAA, 32'h0,        1'b0});
      vecs.push_back('{"ldHs3FFE", 1'b0, 32'h3FFE,     2'd1, 1'b0, 32'h0,        32'hFFFFAAAA, 1'b0});
      vecs.push_back('{"ldW3FFCb", 1'b0, 32'h3FFC,     2'd2, 1'b0, 32'h0,        32'hAAAAF00D, 1'b0});
      vecs.push_back('{"stB3FFF",  1'b1, 32'h3FFF,     2'd0, 1'b0, 32'h0000007F, 32'h0,        1'b0});
      vecs.push_back('{"ldBs3FFF", 1'b0, 32'h3FFF,     2'd0, 1'b0, 32'h0,        32'h0000007F, 1'b0});
      vecs.push_back('{"ldB4000",  1'b0, 32'h4000,     2'd0, 1'b1, 32'h0,        32'h0,        1'b1});
      vecs.push_back('{"ldD18",    1'b0, 32'h18,       2'd3, 1'b0, 32'h0,        32'h0,        1'b1});
      vecs.push_back('{"ldWtop",   1'b0, 32'hFFFFFFFC, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1});
      vecs.push_back('{"stW20",    1'b1, 32'h20,       2'd2, 1'b0, 32'h0BADF00D, 32'h0,        1'b0});
      vecs.push_back('{"stW24",    1'b1, 32'h24,       2'd2, 1'b0, 32'h55555555, 32'h0,        1'b0});
      vecs.push_back('{"stH24",    1'b1, 32'h24,       2'd1, 1'b0, 32'hFFFF1234, 32'h0,        1'b0});
      vecs.push_back('{"ldW24",    1'b0, 32'h24,       2'd2, 1'b0, 32'h0,        32'h55551234, 1'b0});
      vecs.push_back('{"ldHs26",   1'b0, 32'h26,       2'd1, 1'b0, 32'h0,        32'h00005555, 1'b0});
      vecs.push_back('{"stW21",    1'b1, 32'h21,       2'd2, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1});
      vecs.push_back('{"ldW20",    1'b0, 32'h20,       2'd2, 1'b0, 32'h0,        32'h0BADF00D, 1'b0});

      foreach (vecs[i]) begin
         modelAccess(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, expRd, expErr, known);
         runChecked(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    vecs[i].expRd, vecs[i].expErr, 1'b1);
      end

      // Stall: rsp_ready stays low while the three-wait-state copy responds
      modelAccess(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, expRd, expErr, known);
      @(negedge clk);
      reqWe = 1'b0; reqAddr = 32'h10; reqSize = 2'd2; reqUnsigned = 1'b0; reqWdata = '0;
      rspReady = 1'b0; reqValid0 = 1'b1; reqValid3 = 1'b1;
      @(posedge clk);
      #1;
      reqValid0 = 1'b0; reqValid3 = 1'b0;
      early = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         early = early | rspValid3 | reqReady3;
      end
      checkOutput("stallNoEarly", 64'(early), 64'd0);
      @(negedge clk);
      checkOutput("stallValidN4", 64'(rspValid3), 64'd1);
      checkOutput("stallData", 64'(rspRdata3), 64'(expRd));
      cap = rspRdata3;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         stable = stable && rspValid3 && (rspRdata3 == cap) && !reqReady3 && !rspErr3 &&
                  rspValid0 && (rspRdata0 == expRd) && !reqReady0;
      end
      checkOutput("stallHold", 64'(stable), 64'd1);
      rspReady = 1'b1;
      @(negedge clk);
      checkOutput("stallRelease", {rspValid0, rspValid3, reqReady0, reqReady3}, 64'b0011);

      // Reset arrives while a store is waiting in the three-wait-state copy
      @(negedge clk);
      reqWe = 1'b1; reqAddr = 32'h20; reqSize = 2'd2; reqUnsigned = 1'b0; reqWdata = 32'h12345678;
      reqValid3 = 1'b1;
      @(posedge clk);
      #1;
      reqValid3 = 1'b0;
      @(negedge clk);
      checkOutput("abortInWait", {rspValid3, reqReady3}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abortOut", {reqReady3, rspValid3, rspErr3, rspRdata3}, 64'd0);
      rst = 1'b0;
      waitReady("abortReady");
      checkOutput("abortIdleOut", {rspValid3, rspErr3, rspRdata3}, 64'd0);
      modelAccess(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, expRd, expErr, known);
      runChecked("abortLd20", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, expRd, expErr, 1'b1);

      // Randomised run against the model, after pre-filling a window
      for (int w = 0; w < 16; w++) begin
         logic [31:0] d = $urandom;
         modelAccess(1'b1, 32'h100 + 32'(4 * w), 2'd2, 1'b0, d, expRd, expErr, known);
         runChecked("fill", 1'b1, 32'h100 + 32'(4 * w), 2'd2, 1'b0, d, expRd, expErr, 1'b1);
      end
      for (int n = 0; n < 200; n++) begin
         bit          we   = 1'($urandom_range(0, 1));
         bit          uns  = 1'($urandom_range(0, 1));
         logic [1:0]  size = 2'($urandom_range(0, 3));
         logic [31:0] d    = $urandom;
         logic [31:0] a    = ($urandom_range(0, 7) == 0) ? 32'h3FF8 + 32'($urandom_range(0, 15))
                                                         : 32'h100 + 32'($urandom_range(0, 63));
         modelAccess(we, a, size, uns, d, expRd, expErr, known);
         runChecked("rand", we, a, size, uns, d, expRd, expErr, known);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
